// File: rtl/wb_systolic_ctrl.sv
// Wishbone slave that loads weights, buffers input vectors in a FIFO, streams them
// into an external N x N systolic array, drains it and exposes the captured results.
module wb_systolic_ctrl #(
    parameter logic [31:0] BASE_ADDRESS = 32'h3000_0000,
    parameter int          N            = 3,
    parameter int          DW           = 8,
    parameter int          AW           = 16,
    parameter int          FIFO_DEPTH   = 4
) (
    input  logic              caravel_wb_clk_i,
    input  logic              caravel_wb_rst_i,
    input  logic              caravel_wb_stb_i,
    input  logic              caravel_wb_cyc_i,
    input  logic              caravel_wb_we_i,
    input  logic [3:0]        caravel_wb_sel_i,
    input  logic [31:0]       caravel_wb_dat_i,
    input  logic [31:0]       caravel_wb_adr_i,
    output logic              caravel_wb_ack_o,
    output logic [31:0]       caravel_wb_dat_o,
    output logic [N*N*DW-1:0] arr_w,
    output logic [N*DW-1:0]   arr_in,
    output logic              arr_en,
    input  logic [N*AW-1:0]   arr_out,
    input  logic              arr_out_valid
);
    localparam int NN  = N * N;
    localparam int IW  = $clog2(NN);
    localparam int CW  = $clog2(N + 1);
    localparam int DRW = $clog2(2 * N);
    localparam int PW  = $clog2(FIFO_DEPTH);
    localparam int VW  = N * DW;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        RUN   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    logic clk, rst;
    assign clk = caravel_wb_clk_i;
    assign rst = caravel_wb_rst_i;

    state_t         state, state_nxt;
    logic [DW-1:0]  wgt [NN];
    logic [AW-1:0]  results [NN];
    logic [VW-1:0]  fifo_mem [FIFO_DEPTH];
    logic [IW-1:0]  widx, ridx, cap_base;
    logic [CW-1:0]  issued, orow;
    logic [DRW-1:0] drain_cnt;
    logic [PW-1:0]  wptr, rptr;
    logic [PW:0]    count;
    logic           wgt_loaded, err, ovf, fifo_empty, fifo_full;
    logic [2:0]     ofs;
    logic [31:0]    rdata;
    logic           sel, acc, wr, rd, start, clear, wr_wgt, wr_in, rd_res;
    logic           pop, drain, capture, rows_done, can_start, push_ok, push_drop;
    logic           wgt_wr, res_rd, res_last, err_set, go_idle;

    logic unused_bits;
    assign unused_bits = ^{caravel_wb_sel_i, caravel_wb_adr_i[1:0], caravel_wb_dat_i};

    assign ofs   = caravel_wb_adr_i[4:2];
    assign sel   = caravel_wb_stb_i & caravel_wb_cyc_i
                 & (caravel_wb_adr_i[31:5] == BASE_ADDRESS[31:5]) & (ofs <= 3'd4);
    // Every side effect fires on the edge that raises ack, so one access acts once.
    assign acc   = sel & ~caravel_wb_ack_o;
    assign wr    = acc & caravel_wb_we_i;
    assign rd    = acc & ~caravel_wb_we_i;
    assign start = wr && (ofs == 3'd0) && caravel_wb_dat_i[0];
    assign clear = wr && (ofs == 3'd0) && caravel_wb_dat_i[1];
    assign wr_wgt = wr && (ofs == 3'd1);
    assign wr_in  = wr && (ofs == 3'd2);
    assign rd_res = rd && (ofs == 3'd3);

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (PW+1)'(FIFO_DEPTH));
    assign cap_base   = IW'(int'(orow) * N);

    assign rows_done = capture && (orow == CW'(N - 1));
    assign can_start = (state == IDLE) && wgt_loaded && !fifo_empty;
    assign push_ok   = wr_in && (state != DONE) && (!fifo_full || pop);
    assign push_drop = wr_in && (state != DONE) && fifo_full && !pop;
    assign wgt_wr    = wr_wgt && (state == IDLE);
    assign res_rd    = rd_res && (state == DONE);
    assign res_last  = res_rd && (ridx == IW'(NN - 1));
    assign err_set   = (start && !clear && !can_start) || (wr_wgt && (state != IDLE));
    assign go_idle   = clear || res_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (clear) begin
            state_nxt = IDLE;
        end else begin
            case (state)
                IDLE:    if (start && can_start) state_nxt = LOAD;
                LOAD:    state_nxt = RUN;
                RUN: begin
                    if (rows_done)                            state_nxt = DONE;
                    else if (pop && issued == CW'(N - 1))     state_nxt = DRAIN;
                end
                DRAIN:   if (rows_done || drain_cnt == DRW'(2 * N - 2)) state_nxt = DONE;
                DONE:    if (res_last) state_nxt = IDLE;
                default: state_nxt = IDLE;
            endcase
        end
    end

    always_comb begin
        pop     = 1'b0;
        drain   = 1'b0;
        capture = 1'b0;
        if (!clear) begin
            case (state)
                RUN: begin
                    pop     = !fifo_empty;
                    capture = arr_out_valid;
                end
                DRAIN: begin
                    drain   = 1'b1;
                    capture = arr_out_valid;
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata = '0;
        case (ofs)
            3'd0: rdata = {24'b0, err, ovf, wgt_loaded, fifo_full, fifo_empty, state};
            3'd3: if (state == DONE) rdata = 32'(results[ridx]);
            3'd4: rdata = {8'(N), 8'(DW), 8'(AW), 8'(FIFO_DEPTH)};
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            caravel_wb_ack_o <= 1'b0;
            caravel_wb_dat_o <= '0;
        end else begin
            caravel_wb_ack_o <= sel & ~caravel_wb_ack_o;
            caravel_wb_dat_o <= rd ? rdata : '0;
        end
    end

    // Weight bank survives CLEAR; only the write index restarts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NN; k++) wgt[k] <= '0;
            widx       <= '0;
            wgt_loaded <= 1'b0;
        end else if (clear) begin
            widx <= '0;
        end else if (wgt_wr) begin
            wgt[widx] <= caravel_wb_dat_i[DW-1:0];
            if (widx == IW'(NN - 1)) begin
                widx       <= '0;
                wgt_loaded <= 1'b1;
            end else begin
                widx <= widx + 1'b1;
            end
        end
    end

    for (genvar g = 0; g < NN; g++) begin : g_wout
        assign arr_w[g*DW +: DW] = wgt[g];
    end

    always_ff @(posedge clk) begin
        if (push_ok) fifo_mem[wptr] <= caravel_wb_dat_i[VW-1:0];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else if (clear) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push_ok) wptr <= wptr + 1'b1;
            if (pop)     rptr <= rptr + 1'b1;
            if (push_ok && !pop)      count <= count + 1'b1;
            else if (pop && !push_ok) count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_in    <= '0;
            arr_en    <= 1'b0;
            issued    <= '0;
            drain_cnt <= '0;
            orow      <= '0;
            ridx      <= '0;
            err       <= 1'b0;
            ovf       <= 1'b0;
            for (int k = 0; k < NN; k++) results[k] <= '0;
        end else begin
            arr_en <= pop || drain;
            if (pop)        arr_in <= fifo_mem[rptr];
            else if (drain) arr_in <= '0;
            if (pop)   issued    <= issued + 1'b1;
            if (drain) drain_cnt <= drain_cnt + 1'b1;
            if (capture) begin
                for (int c = 0; c < N; c++) results[cap_base + IW'(c)] <= arr_out[c*AW +: AW];
                orow <= orow + 1'b1;
            end
            if (res_rd)    ridx <= ridx + 1'b1;
            if (err_set)   err  <= 1'b1;
            if (push_drop) ovf  <= 1'b1;
            if (go_idle) begin
                issued    <= '0;
                drain_cnt <= '0;
                orow      <= '0;
                ridx      <= '0;
                err       <= 1'b0;
            end
            if (clear) begin
                ovf <= 1'b0;
                for (int k = 0; k < NN; k++) results[k] <= '0;
            end
        end
    end
endmodule
